vxe_intu: RTL

- VxE interrupt unit; sits directly downstream of the register I/O block.
- Latches event pulses from the CU/VPUs into sticky raw bits and applies the interrupt mask from register I/O.
- Drives a single level interrupt line to the host and exposes raw/active state back to register I/O.
- Handles write-1-to-clear acknowledges and enforces a deassertion holdoff so the host sees an edge for every new interrupt.

---
 rtl/vxe_intu.sv | 106 ++++++++++
 1 files changed

// File: rtl/vxe_intu.sv
// ============================================================================
// Module   : vxe_intu
// Brief    : VxE interrupt unit - sticky event latching, masking, W1C acks
//            and a deassertion holdoff on the level interrupt to the host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vxe_intu #(
    parameter int NSRC    = 4,
    parameter int HOLDOFF = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] i_events,
    input  logic [NSRC-1:0] i_msk,
    input  logic            i_ack_vld,
    input  logic [NSRC-1:0] i_ack,
    output logic [NSRC-1:0] o_raw,
    output logic [NSRC-1:0] o_act,
    output logic [NSRC-1:0] o_lost,
    output logic            o_intr
);

    localparam int CNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_INIT = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [NSRC-1:0]  raw, lost;
    logic [NSRC-1:0]  clr, raw_nxt, lost_nxt;
    logic             intr, intr_nxt;

    // An event always wins over a simultaneous ack of the same bit.
    always_comb begin
        clr      = {NSRC{i_ack_vld}} & i_ack;
        raw_nxt  = i_events | (raw & ~clr);
        lost_nxt = (lost & ~clr) | (i_events & raw & ~clr);
    end

    assign o_act = raw & i_msk;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (|o_act) begin
                    state_nxt = ASSERT;
                end
            end
            ASSERT: begin
                if (!(|o_act)) begin
                    if (HOLDOFF > 0) begin
                        state_nxt = HOLD;
                        cnt_nxt   = HOLD_INIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        // Registered from the next state so the line is glitch-free.
        intr_nxt = (state_nxt == ASSERT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raw   <= '0;
            lost  <= '0;
            state <= IDLE;
            cnt   <= '0;
            intr  <= 1'b0;
        end else begin
            raw   <= raw_nxt;
            lost  <= lost_nxt;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            intr  <= intr_nxt;
        end
    end

    assign o_raw  = raw;
    assign o_lost = lost;
    assign o_intr = intr;

endmodule

`default_nettype wire
